// File: rtl/game_pkg.sv
// Shared types and constants for the SkyHop game sequencer.
package game_pkg;

    typedef enum logic [2:0] {
        ST_START     = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_PLAY      = 3'd2,
        ST_LEVEL_UP  = 3'd3,
        ST_GAME_OVER = 3'd4,
        ST_WIN       = 3'd5
    } state_t;

    localparam int LEVEL_W = 4;
    localparam int LIVES_W = 2;
    localparam int MS_W    = 16;

    localparam int COUNTDOWN_MS_DEF = 3000;
    localparam int LEVELUP_MS_DEF   = 1000;
    localparam int END_MS_DEF       = 2000;
    localparam int LEVEL_MAX_DEF    = 9;
    localparam int LIVES_INIT_DEF   = 3;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser for an asynchronous input followed by a rising-edge pulse.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    // sync[0], sync[1] are the synchroniser stages; sync[2] holds the previous sample
    logic [2:0] sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[1:0], din};
        end
    end

    assign pulse = sync[1] & ~sync[2];

endmodule

// File: rtl/game_controller.sv
// SkyHop game sequencer: state machine, ms timer, level/lives tracking and
// registered overlay/physics controls decoded from the next state.
//
// state        | meaning
// -------------+---------------------------------------------------------
// START        | start screen, waiting for the start button
// COUNTDOWN    | pre-play countdown, time bar shown but not running
// PLAY         | player active, time bar running
// LEVEL_UP     | level-up banner hold
// GAME_OVER    | out of lives, alarm palette, restart locked for END_MS
// WIN          | last level cleared, restart locked for END_MS
module game_controller
    import game_pkg::*;
#(
    parameter int COUNTDOWN_MS = COUNTDOWN_MS_DEF,
    parameter int LEVELUP_MS   = LEVELUP_MS_DEF,
    parameter int END_MS       = END_MS_DEF,
    parameter int LEVEL_MAX    = LEVEL_MAX_DEF,
    parameter int LIVES_INIT   = LIVES_INIT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               one_ms_tick,
    input  logic               btn_start,
    input  logic               time_elapsed,
    input  logic               player_fell,
    input  logic               level_clear,
    output logic               start_screen_en,
    output logic               time_bar_en,
    output logic               time_bar_start,
    output logic               bg_color_select,
    output logic               play_en,
    output logic [LEVEL_W-1:0] level,
    output logic [LIVES_W-1:0] lives,
    output logic [2:0]         state
);

    localparam logic [MS_W-1:0]    CD_LAST   = MS_W'(COUNTDOWN_MS - 1);
    localparam logic [MS_W-1:0]    LU_LAST   = MS_W'(LEVELUP_MS - 1);
    localparam logic [MS_W-1:0]    END_LIM   = MS_W'(END_MS);
    localparam logic [LEVEL_W-1:0] LVL_LAST  = LEVEL_W'(LEVEL_MAX);
    localparam logic [LIVES_W-1:0] LIVES_RST = LIVES_W'(LIVES_INIT);

    state_t             state_q, state_n;
    logic [MS_W-1:0]    ms_cnt, ms_n;
    logic [LEVEL_W-1:0] level_n;
    logic [LIVES_W-1:0] lives_n;
    logic               start_pulse;
    logic               fail;
    logic               end_state;
    logic               sse_n, tbe_n, tbs_n, bg_n, play_n;

    edge_sync u_start_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (btn_start),
        .pulse (start_pulse)
    );

    assign fail      = time_elapsed | player_fell;
    assign end_state = (state_q == ST_GAME_OVER) || (state_q == ST_WIN);

    always_comb begin
        state_n = state_q;
        level_n = level;
        lives_n = lives;
        case (state_q)
            ST_START: begin
                if (start_pulse) begin
                    level_n = LEVEL_W'(1);
                    lives_n = LIVES_RST;
                    state_n = ST_COUNTDOWN;
                end
            end
            ST_COUNTDOWN: begin
                if (one_ms_tick && ms_cnt == CD_LAST) state_n = ST_PLAY;
            end
            ST_PLAY: begin
                // a failure in the same cycle as level_clear takes priority
                if (fail) begin
                    if (lives <= LIVES_W'(1)) begin
                        lives_n = '0;
                        state_n = ST_GAME_OVER;
                    end else begin
                        lives_n = lives - 1'b1;
                        state_n = ST_COUNTDOWN;
                    end
                end else if (level_clear) begin
                    if (level >= LVL_LAST) begin
                        state_n = ST_WIN;
                    end else begin
                        level_n = level + 1'b1;
                        state_n = ST_LEVEL_UP;
                    end
                end
            end
            ST_LEVEL_UP: begin
                if (one_ms_tick && ms_cnt == LU_LAST) state_n = ST_COUNTDOWN;
            end
            ST_GAME_OVER, ST_WIN: begin
                if (start_pulse && ms_cnt >= END_LIM) state_n = ST_START;
            end
            default: state_n = ST_START;
        endcase
    end

    always_comb begin
        ms_n = ms_cnt;
        if (state_n != state_q) begin
            ms_n = '0;
        end else if (one_ms_tick) begin
            if (end_state && ms_cnt >= END_LIM) ms_n = END_LIM;
            else                                 ms_n = ms_cnt + 1'b1;
        end
    end

    always_comb begin
        sse_n  = (state_n == ST_START);
        tbe_n  = (state_n == ST_COUNTDOWN) || (state_n == ST_PLAY) || (state_n == ST_LEVEL_UP);
        tbs_n  = (state_n == ST_PLAY);
        play_n = (state_n == ST_PLAY);
        bg_n   = (state_n == ST_GAME_OVER) ||
                 ((state_n == ST_COUNTDOWN) && (lives_n == LIVES_W'(1)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_START;
            ms_cnt          <= '0;
            level           <= LEVEL_W'(1);
            lives           <= LIVES_RST;
            start_screen_en <= 1'b1;
            time_bar_en     <= 1'b0;
            time_bar_start  <= 1'b0;
            bg_color_select <= 1'b0;
            play_en         <= 1'b0;
        end else begin
            state_q         <= state_n;
            ms_cnt          <= ms_n;
            level           <= level_n;
            lives           <= lives_n;
            start_screen_en <= sse_n;
            time_bar_en     <= tbe_n;
            time_bar_start  <= tbs_n;
            bg_color_select <= bg_n;
            play_en         <= play_n;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_game_controller.sv
// Randomised bench for game_controller: a game-rules model predicts every cycle's
// outputs into a queue, and a monitor compares them against the DUT.
module tb_game_controller;

    localparam int CD_MS    = 20;
    localparam int LU_MS    = 8;
    localparam int END_MS   = 12;
    localparam int LVL_MAX  = 9;
    localparam int LIVES0   = 3;
    localparam int N_CYCLES = 20000;

    localparam int S_START = 0, S_CD = 1, S_PLAY = 2, S_LU = 3, S_GO = 4, S_WIN = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0, btn = 1'b0, te = 1'b0, pf = 1'b0, lc = 1'b0;
    logic       start_screen_en, time_bar_en, time_bar_start, bg_color_select, play_en;
    logic [3:0] level;
    logic [1:0] lives;
    logic [2:0] state;
    logic [13:0] got, e;

    always #5 clk = ~clk;

    game_controller #(
        .COUNTDOWN_MS (CD_MS),
        .LEVELUP_MS   (LU_MS),
        .END_MS       (END_MS),
        .LEVEL_MAX    (LVL_MAX),
        .LIVES_INIT   (LIVES0)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .one_ms_tick     (tick),
        .btn_start       (btn),
        .time_elapsed    (te),
        .player_fell     (pf),
        .level_clear     (lc),
        .start_screen_en (start_screen_en),
        .time_bar_en     (time_bar_en),
        .time_bar_start  (time_bar_start),
        .bg_color_select (bg_color_select),
        .play_en         (play_en),
        .level           (level),
        .lives           (lives),
        .state           (state)
    );

    assign got = {start_screen_en, time_bar_en, time_bar_start, bg_color_select,
                  play_en, level, lives, state};

    logic [13:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    // game-rules model: ticks left in timed states, ticks left before restart allowed
    int   m_state, m_level, m_lives, m_left, m_wait;
    logic btn_hist [0:2];

    function automatic logic [13:0] expected();
        logic bg;
        bg = (m_state == S_GO) || (m_state == S_CD && m_lives == 1);
        return {m_state == S_START,
                (m_state == S_CD || m_state == S_PLAY || m_state == S_LU),
                m_state == S_PLAY, bg, m_state == S_PLAY,
                4'(m_level), 2'(m_lives), 3'(m_state)};
    endfunction

    task automatic model_reset();
        m_state = S_START;
        m_level = 1;
        m_lives = LIVES0;
        m_left  = 0;
        m_wait  = 0;
        for (int i = 0; i < 3; i++) btn_hist[i] = 1'b0;
    endtask

    task automatic enter(input int s);
        m_state = s;
        if (s == S_CD) m_left = CD_MS;
        if (s == S_LU) m_left = LU_MS;
        if (s == S_GO || s == S_WIN) m_wait = END_MS;
    endtask

    task automatic model_edge(input logic t, input logic b, input logic fl, input logic clr);
        logic pulse;
        pulse = btn_hist[1] & ~btn_hist[2];
        btn_hist[2] = btn_hist[1];
        btn_hist[1] = btn_hist[0];
        btn_hist[0] = b;
        case (m_state)
            S_START:
                if (pulse) begin
                    m_level = 1;
                    m_lives = LIVES0;
                    enter(S_CD);
                end
            S_CD, S_LU:
                if (t) begin
                    if (m_left == 1) enter(m_state == S_CD ? S_PLAY : S_CD);
                    else m_left--;
                end
            S_PLAY:
                if (fl) begin
                    m_lives--;
                    enter(m_lives == 0 ? S_GO : S_CD);
                end else if (clr) begin
                    if (m_level == LVL_MAX) enter(S_WIN);
                    else begin
                        m_level++;
                        enter(S_LU);
                    end
                end
            default:
                if (pulse && m_wait == 0) enter(S_START);
                else if (t && m_wait > 0) m_wait--;
        endcase
    endtask

    // monitor
    initial begin
        forever begin
            @(posedge clk or negedge rst);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL outputs t=%0t got=%h exp=%h (state %0d/%0d level %0d/%0d lives %0d/%0d)",
                             $time, got, e, got[2:0], e[2:0], got[8:5], e[8:5], got[4:3], e[4:3]);
                end
            end
        end
    end

    // stimulus
    initial begin
        int  mode;
        int  rst_hold;
        bit  mid_reset_done;
        mode = 0;
        rst_hold = 0;
        mid_reset_done = 0;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            exp_q.push_back(expected());
        end
        @(negedge clk);
        rst = 1'b1;
        model_edge(tick, btn, 1'b0, 1'b0);
        exp_q.push_back(expected());

        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(negedge clk);
            if (m_state == S_START) mode = int'($urandom_range(0, 2));

            if (rst == 1'b0) begin
                if (rst_hold == 0) rst = 1'b1;
                else rst_hold--;
            end else if ($urandom_range(0, 2999) == 0 ||
                         (!mid_reset_done && m_state == S_PLAY && cyc > 2000)) begin
                rst = 1'b0;
                rst_hold = int'($urandom_range(0, 2));
                mid_reset_done = 1;
                model_reset();
                exp_q.push_back(expected());
            end

            tick = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 11) == 0) btn = ~btn;
            case (mode)
                0: begin
                    lc = ($urandom_range(0, 5) == 0);
                    pf = ($urandom_range(0, 79) == 0);
                    te = ($urandom_range(0, 79) == 0);
                end
                1: begin
                    lc = ($urandom_range(0, 29) == 0);
                    pf = ($urandom_range(0, 5) == 0);
                    te = ($urandom_range(0, 7) == 0);
                end
                default: begin
                    lc = ($urandom_range(0, 9) == 0);
                    pf = ($urandom_range(0, 9) == 0);
                    te = ($urandom_range(0, 19) == 0);
                    if ($urandom_range(0, 15) == 0) begin
                        lc = 1'b1;
                        pf = 1'b1;
                    end
                end
            endcase

            if (rst == 1'b0) model_reset();
            else model_edge(tick, btn, te | pf, lc);
            exp_q.push_back(expected());
        end

        @(posedge clk);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain left=%0d expected=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/game_controller.md
# game_controller

Top-level game sequencer for SkyHop, clocked on the 40 MHz pixel clock. It runs the game state machine from start screen through countdown, play, level-up and game-over/win. It drives the enable/start/colour controls of the background, start-screen and time-bar pipeline stages, and it tracks the current level and remaining lives.

## Interface
Parameters:
- COUNTDOWN_MS, 3000: pre-play countdown length in one_ms_tick pulses
- LEVELUP_MS, 1000: level-up banner hold length in ms
- END_MS, 2000: minimum GAME_OVER/WIN hold before restart is accepted
- LEVEL_MAX, 9: last level; clearing it goes to WIN
- LIVES_INIT, 3: lives at game start (1..3)

Ports:
- clk  in  1  40 MHz pixel clock
- rst  in  1  asynchronous, active-low reset
- one_ms_tick  in  1  single-cycle pulse every 1 ms
- btn_start  in  1  raw push button, asynchronous to clk
- time_elapsed  in  1  time bar ran out (level)
- player_fell  in  1  player left the platforms (single-cycle pulse)
- level_clear  in  1  goal reached (single-cycle pulse)
- start_screen_en  out  1  start-screen overlay enable
- time_bar_en  out  1  time-bar overlay enable
- time_bar_start  out  1  time bar running (level; 0 re-arms the bar)
- bg_color_select  out  1  0 = day palette, 1 = alarm palette
- play_en  out  1  player physics/input enable
- level  out  4  current level, 1..LEVEL_MAX
- lives  out  2  remaining lives
- state  out  3  encoded state, for debug/LED

## Operation
- btn_start passes through a 2-flop synchroniser and then a rising-edge detector, giving start_pulse. Reset value of the flops is 0.
- States and encodings:
  - START=0
  - COUNTDOWN=1
  - PLAY=2
  - LEVEL_UP=3
  - GAME_OVER=4
  - WIN=5
  - Encodings 6–7 are illegal and go to START.
- Transitions:
  - START: on start_pulse, set level=1 and lives=LIVES_INIT, then go to COUNTDOWN.
  - COUNTDOWN: after COUNTDOWN_MS ticks, go to PLAY.
  - PLAY, failure (time_elapsed or player_fell): if lives==1, set lives=0 and go to GAME_OVER. Otherwise lives−1 and go to COUNTDOWN; the level is unchanged.
  - PLAY, level_clear: if level==LEVEL_MAX, go to WIN. Otherwise level+1 and go to LEVEL_UP.
  - PLAY, failure and level_clear in the same cycle: failure wins.
  - LEVEL_UP: after LEVELUP_MS ticks, go to COUNTDOWN.
  - GAME_OVER/WIN: start_pulse is ignored until END_MS ticks have elapsed. After that, start_pulse goes to START. level and lives hold their values for display.
- ms counter:
  - 16-bit, cleared to 0 on every state change.
  - Increments on one_ms_tick.
  - A timed transition fires on the tick where ms_cnt==N−1, so the state lasts exactly N ticks.
  - In GAME_OVER/WIN it saturates at END_MS.
- Outputs are registered and decoded from the next state, so they change in the same edge as state:
  - start_screen_en=1 in START only.
  - time_bar_en=1 in COUNTDOWN, PLAY and LEVEL_UP.
  - time_bar_start=1 in PLAY only.
  - play_en=1 in PLAY only.
  - bg_color_select=1 in GAME_OVER, and in COUNTDOWN when lives==1.
- Inputs time_elapsed, player_fell and level_clear are ignored outside PLAY.

## Timing
- Reset (rst=0) takes effect immediately, asynchronously. While reset is held:
  - state=START, ms_cnt=0
  - level=1, lives=LIVES_INIT
  - start_screen_en=1
  - all other outputs 0
- Reset deassertion is synchronous to clk through the flops.
- btn_start to state change takes 3 clk: 2 synchroniser stages plus the edge/state register.
- PLAY event input to output change takes 1 clk.
- Reset mid-operation aborts immediately to START. No pending transition survives reset.
- one_ms_tick coincident with a state change is not counted for the new state.
- level never exceeds LEVEL_MAX and never wraps. lives never underflows below 0.

## Structure
- Shared package game_pkg holds:
  - the state enum/localparams (START..WIN)
  - the LEVEL_W=4 and LIVES_W=2 widths
  - the default ms constants
- Sub-module edge_sync (2-flop synchroniser plus rising-edge pulse) is reused for future jump/button inputs.
- The state register, ms counter and level/lives registers live in game_controller.

## Test plan
- **Reset:** hold rst=0 mid-PLAY → state=0, start_screen_en=1, level=1, lives=3, all other outputs 0 within the same cycle.
- **Start and countdown:** btn_start press → COUNTDOWN at +3 clk. After exactly 3000 one_ms_tick pulses → PLAY, time_bar_start=1, play_en=1. At 2999 ticks, still COUNTDOWN.
- **Failure path:** in PLAY at lives=3, pulse player_fell → COUNTDOWN, lives=2, level unchanged. Next, time_elapsed → lives=1 and bg_color_select=1 in COUNTDOWN. Third failure → GAME_OVER, lives=0.
- **Simultaneous events:** level_clear and player_fell in the same cycle at lives=2 → COUNTDOWN, lives=1, level unchanged.
- **Level-up and win:** level_clear at level 3 → LEVEL_UP, level=4. After 1000 ticks → COUNTDOWN. At level 9, level_clear → WIN, level stays 9.
- **End-state lockout:** in GAME_OVER, btn_start at tick 500 is ignored. btn_start after 2000 ticks → START, start_screen_en=1.
